// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_subtract_ctrl_pkg;

    // Controller states; encodings are fixed so they stay stable in waveforms and netlists.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtract_ctrl_fullsubtractor.sv
// One-bit full subtractor cell: computes Ain - Bin - Cin.
module fullsubtractor (
    input  logic Ain,
    input  logic Bin,
    input  logic Cin,
    output logic S,
    output logic D
);

    // Difference bit and borrow-out for a single bit slice.
    always_comb begin
        S = Ain ^ Bin ^ Cin;
        D = (~Ain & (Bin | Cin)) | (Bin & Cin);
    end

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB-first
// through a single full-subtractor cell, with valid/ready on both sides.
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;

    logic cell_s;
    logic cell_d;

    fullsubtractor u_cell (
        .Ain (a_sh_q[0]),
        .Bin (b_sh_q[0]),
        .Cin (borrow_q),
        .S   (cell_s),
        .D   (cell_d)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Next-state, slice sequencing and handshake outputs; clr overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        borrow_d  = borrow_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);

        if (clr) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            borrow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_d   = a;
                        b_sh_d   = b;
                        borrow_d = bin;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result fills from the MSB so after WIDTH slices bit 0 holds the LSB.
                    diff_d            = diff_q >> 1;
                    diff_d[WIDTH-1]   = cell_s;
                    a_sh_d            = a_sh_q >> 1;
                    b_sh_d            = b_sh_q >> 1;
                    borrow_d          = cell_d;
                    cnt_d             = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bout_d  = cell_d;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed and randomised checks for serial_subtract_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_subtract_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] diff1;
    logic       bout1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    serial_subtract_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .bin       (bin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .bout      (bout1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return one cycle after the accept edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        bin = bi;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycle count includes the accept cycle.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        if (!out_valid) check_eq("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      input int stall, input logic [7:0] exp_d, input logic exp_b);
        int cyc;
        send(av, bv, bi);
        wait_done(cyc);
        repeat (stall) step();
        check_eq({tag, "_diff"}, 32'(diff), 32'(exp_d));
        check_eq({tag, "_bout"}, 32'(bout), 32'(exp_b));
        take();
    endtask

    initial begin
        int cyc;
        logic saw_valid;
        logic [7:0] ra, rb;
        logic rbi;
        logic [8:0] full;

        // Reset values
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: basic op and latency
        send(8'd200, 8'd55, 1'b0);
        wait_done(cyc);
        check_eq("t1_latency", 32'(cyc), 32'd9);
        check_eq("t1_diff", 32'(diff), 32'd145);
        check_eq("t1_bout", 32'(bout), 32'd0);
        take();

        // 2: underflow and borrow-in only
        op("t2a", 8'd5, 8'd10, 1'b0, 0, 8'd251, 1'b1);
        op("t2b", 8'd0, 8'd0, 1'b1, 0, 8'd255, 1'b1);

        // 3: backpressure for 20 cycles
        send(8'd77, 8'd33, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("t3_hold_diff", 32'(diff), 32'd44);
            check_eq("t3_hold_bout", 32'(bout), 32'd0);
            check_eq("t3_hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("t3_hold_out_valid", 32'(out_valid), 32'd1);
        end
        take();
        check_eq("t3_idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("t3_idle_out_valid", 32'(out_valid), 32'd0);

        // 4: in_valid during RUN is ignored
        send(8'd9, 8'd3, 1'b0);
        a = 8'd1;
        b = 8'd1;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        wait_done(cyc);
        check_eq("t4_diff", 32'(diff), 32'd6);
        check_eq("t4_bout", 32'(bout), 32'd0);
        take();
        step();
        check_eq("t4_no_extra_op", 32'(out_valid), 32'd0);

        // 5: async reset mid-RUN
        send(8'd200, 8'd55, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("t5_rst_diff", 32'(diff), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        op("t5_after", 8'd100, 8'd1, 1'b0, 0, 8'd99, 1'b0);

        // 6: clr at RUN cycle 3, competing in_valid not taken, bout held
        op("t6_pre", 8'd5, 8'd10, 1'b0, 0, 8'd251, 1'b1);
        send(8'd9, 8'd3, 1'b0);
        repeat (2) step();
        clr = 1'b1;
        in_valid = 1'b1;
        a = 8'd1;
        b = 8'd1;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        check_eq("t6_clr_in_ready", 32'(in_ready), 32'd1);
        check_eq("t6_clr_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_clr_bout_held", 32'(bout), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid || !in_ready) saw_valid = 1'b1;
        end
        check_eq("t6_stays_idle", 32'(saw_valid), 32'd0);
        op("t6_after", 8'd50, 8'd20, 1'b1, 1, 8'd29, 1'b0);

        // 6b: WIDTH=1 build
        a1 = 1'b0;
        b1 = 1'b1;
        bin1 = 1'b0;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check_eq("w1_run_no_valid", 32'(out_valid1), 32'd0);
        step();
        check_eq("w1_out_valid", 32'(out_valid1), 32'd1);
        check_eq("w1_diff", 32'(diff1), 32'd1);
        check_eq("w1_bout", 32'(bout1), 32'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check_eq("w1_idle", 32'(in_ready1), 32'd1);

        // Scoreboard: random operands and random result stalls
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            op("rand", ra, rb, rbi, $urandom_range(0, 3), full[7:0], full[8]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
